// File: rtl/mux_scan_if.sv
// Bundles the sequencer's control inputs, its mux-facing select/sample pair and its result outputs.
// The master is the environment: it drives start, auto, ch_mask and y_in. The slave is the sequencer.
interface mux_scan_if;
  logic       start;
  logic       auto;
  logic [3:0] ch_mask;
  logic       y_in;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] snapshot;
  logic [3:0] delta;

  modport master (
    output start, auto, ch_mask, y_in,
    input  sel, busy, done, snapshot, delta
  );

  modport slave (
    input  start, auto, ch_mask, y_in,
    output sel, busy, done, snapshot, delta
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Round-robin scanner for a 4:1 mux. It steps sel over the enabled channels and samples y_in after
// SETTLE_CYC wait cycles. It publishes a 4-bit snapshot together with the bits that changed since the last one.
module mux_scan_sequencer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state;
  logic [3:0] mask_r;
  logic [3:0] shadow;
  logic [3:0] cnt;
  logic [3:0] merged;
  logic [1:0] first_sel;
  logic [1:0] next_sel;
  logic       has_next;
  logic       launch;

  // NOTE: every always_comb output gets a default first so that no path leaves it unassigned (no latch).
  always_comb begin
    first_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.ch_mask[i]) first_sel = 2'(i);
    end
  end

  // Next enabled channel strictly above the current one. The scan never wraps.
  always_comb begin
    has_next = 1'b0;
    next_sel = bus.sel;
    for (int i = 3; i >= 0; i--) begin
      if (mask_r[i] && (i > int'(bus.sel))) begin
        has_next = 1'b1;
        next_sel = 2'(i);
      end
    end
  end

  always_comb begin
    merged          = shadow;
    merged[bus.sel] = bus.y_in;
  end

  assign launch = ((state == IDLE) && bus.start) || ((state == DONE) && bus.auto);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_r       <= 4'h0;
      shadow       <= 4'h0;
      cnt          <= 4'h0;
      bus.sel      <= 2'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.snapshot <= 4'h0;
      bus.delta    <= 4'h0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            mask_r   <= bus.ch_mask;
            shadow   <= 4'h0;
            bus.busy <= 1'b1;
            // The decision uses the mask being latched on this edge, not the stale mask_r.
            if (bus.ch_mask != 4'h0) begin
              bus.sel <= first_sel;
              cnt     <= SETTLE;
              state   <= SCAN;
            end else begin
              bus.snapshot <= 4'h0;
              bus.delta    <= bus.snapshot;
              bus.done     <= 1'b1;
              state        <= DONE;
            end
          end else if (state == DONE) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        SCAN: begin
          if (cnt != 4'h0) begin
            cnt <= cnt - 4'd1;
          end else begin
            shadow <= merged;
            if (has_next) begin
              bus.sel <= next_sel;
              cnt     <= SETTLE;
            end else begin
              bus.snapshot <= merged;
              bus.delta    <= merged ^ bus.snapshot;
              bus.done     <= 1'b1;
              state        <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench for mux_scan_sequencer. The expected select sequence, latency, snapshot
// and delta come from the list of enabled channels and the modelled mux inputs.
module tb_mux_scan_sequencer;

  localparam int S = 1;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_vec;
  logic [3:0] prev_snap;
  logic [1:0] exp_sel;
  int         checks;
  int         errors;

  mux_scan_if bus ();

  mux_scan_sequencer #(.SETTLE_CYC(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // The mux being scanned: its output is the selected bit of i_vec.
  assign bus.y_in = i_vec[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_sel"},  32'(bus.sel), 32'(exp_sel));
  endtask

  // Entered at #1 after the launch edge. Runs through the done cycle.
  task automatic scan_body(input logic [3:0] mask, input logic [3:0] ival, input bit noisy);
    int         chans[$];
    logic [3:0] exp_snap;
    i_vec = ival;
    for (int c = 0; c < 4; c++) if (mask[c]) chans.push_back(c);
    exp_snap = ival & mask;
    for (int j = 0; j < chans.size() * (S + 1); j++) begin
      check("scan_sel",  32'(bus.sel), 32'(chans[j / (S + 1)]));
      check("scan_busy", 32'(bus.busy), 1);
      check("scan_done", 32'(bus.done), 0);
      check("scan_snap", 32'(bus.snapshot), 32'(prev_snap));
      if (noisy) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.ch_mask = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 1);
    check("done_busy",  32'(bus.busy), 1);
    check("snapshot",   32'(bus.snapshot), 32'(exp_snap));
    check("delta",      32'(bus.delta), 32'(exp_snap ^ prev_snap));
    prev_snap = exp_snap;
    if (chans.size() > 0) exp_sel = 2'(chans[chans.size() - 1]);
  endtask

  task automatic start_scan(input logic [3:0] mask, input logic [3:0] ival, input bit noisy);
    bus.ch_mask = mask;
    i_vec       = ival;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scan_body(mask, ival, noisy);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    prev_snap   = 4'h0;
    exp_sel     = 2'd0;
    i_vec       = 4'h0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.auto    = 1'b0;
    bus.ch_mask = 4'h0;

    #12;
    check("rst_sel",   32'(bus.sel), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_snap",  32'(bus.snapshot), 0);
    check("rst_delta", 32'(bus.delta), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("idle0");

    // Full mask, 0101 mask, then an empty mask.
    start_scan(4'hF, 4'hA, 1'b0);
    @(posedge clk); #1; check_idle("idle_f");
    start_scan(4'b0101, 4'hF, 1'b0);
    @(posedge clk); #1; check_idle("idle_5");
    start_scan(4'h0, 4'h3, 1'b0);
    @(posedge clk); #1; check_idle("idle_0");

    // Auto restart with no IDLE cycle in between. Clear auto mid-scan to stop after the second scan.
    bus.auto = 1'b1;
    start_scan(4'hF, 4'hA, 1'b0);
    bus.ch_mask = 4'hF;
    @(posedge clk); #1;
    bus.auto = 1'b0;
    scan_body(4'hF, 4'hC, 1'b0);
    check("auto_delta", 32'(bus.delta), 32'h6);
    @(posedge clk); #1; check_idle("idle_auto");

    // Extra start during SCAN, then an asynchronous reset in cycle 3 of the scan.
    bus.ch_mask = 4'hF;
    i_vec       = 4'h5;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("midscan_sel",  32'(bus.sel), 1);
    check("midscan_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel",   32'(bus.sel), 0);
    check("arst_busy",  32'(bus.busy), 0);
    check("arst_done",  32'(bus.done), 0);
    check("arst_snap",  32'(bus.snapshot), 0);
    check("arst_delta", 32'(bus.delta), 0);
    prev_snap = 4'h0;
    exp_sel   = 2'd0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    check_idle("idle_arst");
    start_scan(4'b0110, 4'($urandom), 1'b0);
    @(posedge clk); #1; check_idle("idle_fresh");

    // Random scans with noise on start and ch_mask while scanning.
    for (int n = 0; n < 25; n++) begin
      start_scan(4'($urandom), 4'($urandom), 1'b1);
      @(posedge clk); #1;
      check_idle("idle_rand");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check_idle("gap_rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 4:1 select mux.
- Steps the 2-bit select lines over the enabled input channels in round-robin order. After a programmable settle time it samples the mux output for each channel.
- Assembles the samples into a 4-bit snapshot and reports which bits changed since the previous snapshot.
- Sits between the control logic (start, mask) and the mux: it drives the mux select and consumes the mux output.

Parameters:
- SETTLE_CYC, default 1, wait cycles after a select change before sampling the mux output. Legal range 0..15; counter is 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one scan; sampled only in IDLE, or in DONE when auto=1
- auto  input  1  1 = restart a new scan immediately after each DONE
- ch_mask  input  4  channel enable; bit n enables channel n; latched when a scan starts
- y_in  input  1  mux output being sampled
- sel  output  2  select lines to the mux
- busy  output  1  high in SCAN and DONE states
- done  output  1  one-cycle pulse: snapshot valid and updated
- snapshot  output  4  last completed scan; masked channels read 0
- delta  output  4  snapshot XOR previous snapshot; updated together with snapshot

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sel=2'b00, busy=0, done=0, snapshot=4'h0, delta=4'h0.
  - Internal mask, shadow register and counter cleared.
  - Reset asserted mid-scan aborts the scan; no partial snapshot is published.
- All outputs are registered.
- States: IDLE, SCAN, DONE.
- IDLE:
  - sel holds its last value.
  - On an edge with start=1: latch ch_mask into mask_r and clear the shadow.
  - If mask_r != 0: sel <= lowest enabled channel, cnt <= SETTLE_CYC, go to SCAN.
  - If mask_r == 0: go directly to DONE with snapshot <= 0 and delta <= old snapshot.
- SCAN:
  - Each edge with cnt != 0: cnt decrements.
  - On the edge with cnt == 0: capture y_in into shadow[sel].
  - If a higher-numbered enabled channel remains: sel <= next enabled channel (ascending, skipping masked channels, no wrap within a scan) and cnt <= SETTLE_CYC.
  - Otherwise: snapshot <= shadow with the captured bit merged in, delta <= that value XOR old snapshot, go to DONE.
  - Each enabled channel therefore costs SETTLE_CYC+1 cycles.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: if auto=1, re-latch ch_mask and restart as in IDLE (start not required). Otherwise go to IDLE.
- Latency: with k enabled channels and the start edge E0, done is high in the cycle following edge E0 + k*(SETTLE_CYC+1). With k=0, done is high in the cycle following E0.
- start while in SCAN: ignored. No queuing.
- ch_mask changes during SCAN: no effect until the next latch.
- snapshot and delta are stable throughout a scan. They change only on entry to DONE.
- busy=0 only in IDLE. done is never high in IDLE.
- Clearing auto during a scan: the current scan completes, then the block goes to IDLE.

Test Plan:
- Reset then idle: rst_n=0 mid-operation -> sel=0, busy=0, done=0, snapshot=0, delta=0 immediately, without waiting for a clock edge.
- SETTLE_CYC=1, ch_mask=4'hF, y_in modelled as a mux over i=4'b1010 -> sel steps 0,1,2,3, each held 2 cycles; done after 8 cycles; snapshot=4'hA, delta=4'hA.
- ch_mask=4'b0101, i=4'b1111 -> sel visits 0 then 2 only; snapshot=4'b0101; done after 4 cycles (SETTLE_CYC=1).
- ch_mask=0, start=1 -> done in the next cycle; snapshot=0; delta equals the prior snapshot.
- auto=1, i changes 4'hA -> 4'hC between scans -> back-to-back done pulses with no IDLE cycle; second delta=4'h6.
- start pulsed during SCAN, and rst_n pulsed low at cycle 3 of a scan -> extra start ignored; after reset snapshot=0 and the next start begins a fresh scan from the lowest enabled channel.
